// File: rtl/kypd_scan_ctrl_if.sv
// Key-event channel of the keypad scanner: valid/ready handshake plus status flags.
interface kypd_scan_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       key_held;
  logic       overflow;

  modport master (output key_valid, output key_code, output key_held, output overflow,
                  input key_ready);
  modport slave  (input key_valid, input key_code, input key_held, input overflow,
                  output key_ready);
endinterface

// File: rtl/kypd_scan_ctrl.sv
// PmodKYPD 4x4 scanner: column drive, row sampling, sweep-level debounce and
// one-deep event holding register on a valid/ready channel.
module kypd_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           row,
  output logic [3:0]           col,
  kypd_scan_ctrl_if.master     evt
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX     = RW'(DEBOUNCE_SCANS);
  // Candidate encoding: {found, code}; found=0 means no key (NONE)
  localparam logic [4:0] KEY_NONE = 5'b0_0000;

  typedef enum logic {ST_DRIVE = 1'b0, ST_SAMPLE = 1'b1} state_t;

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    case ({c, r})
      4'b00_00: k = 4'h1;  4'b00_01: k = 4'h4;  4'b00_10: k = 4'h7;  4'b00_11: k = 4'h0;
      4'b01_00: k = 4'h2;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h8;  4'b01_11: k = 4'hF;
      4'b10_00: k = 4'h3;  4'b10_01: k = 4'h6;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hE;
      4'b11_00: k = 4'hA;  4'b11_01: k = 4'hB;  4'b11_10: k = 4'hC;  4'b11_11: k = 4'hD;
      default:  k = 4'h0;
    endcase
    return k;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [1:0]      col_idx_r, col_idx_nxt_s;
  logic [3:0]      col_r;
  logic [3:0]      row_meta_r, row_sync_r;
  logic [4:0]      cand_r, col_cand_s, sweep_cand_s;
  logic [4:0]      prev_cand_r, stable_r, stable_nxt_s, last_r, last_nxt_s;
  logic [RW-1:0]   run_r, run_nxt_s;
  logic            sample_s, sweep_end_s, evt_s;
  logic            valid_r, valid_nxt_s, held_r, ovf_r, ovf_nxt_s;
  logic [3:0]      code_r, code_nxt_s;

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // Scan sequencer next-state: DRIVE for SETTLE_CYCLES, then one SAMPLE cycle
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    col_idx_nxt_s = col_idx_r;
    sample_s      = 1'b0;
    case (state_r)
      ST_DRIVE: begin
        if (cnt_r == SETTLE_LAST) begin
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = ST_SAMPLE;
        end else begin
          cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_SAMPLE: begin
        sample_s      = 1'b1;
        col_idx_nxt_s = col_idx_r + 2'd1;
        state_nxt_s   = ST_DRIVE;
      end
      default: begin
        state_nxt_s   = ST_DRIVE;
        cnt_nxt_s     = {CW{1'b0}};
        col_idx_nxt_s = 2'd0;
      end
    endcase
  end

  // Candidate, debounce, event and holding-register next values
  always_comb begin
    col_cand_s = KEY_NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_r[r]) begin
        col_cand_s = {1'b1, key_map(col_idx_r, 2'(r))};
      end else begin
        col_cand_s = col_cand_s;
      end
    end
    // Earlier columns win; column 0 starts a fresh sweep
    if (col_idx_r == 2'd0 || !cand_r[4]) begin
      sweep_cand_s = col_cand_s;
    end else begin
      sweep_cand_s = cand_r;
    end
    sweep_end_s = sample_s && (col_idx_r == 2'd3);

    if (sweep_cand_s == prev_cand_r) begin
      run_nxt_s = (run_r == RUN_MAX) ? run_r : run_r + {{(RW-1){1'b0}}, 1'b1};
    end else begin
      run_nxt_s = {{(RW-1){1'b0}}, 1'b1};
    end
    if (sweep_end_s && (run_nxt_s >= RUN_MAX)) begin
      stable_nxt_s = sweep_cand_s;
    end else begin
      stable_nxt_s = stable_r;
    end

    evt_s = sweep_end_s && stable_nxt_s[4] && (stable_nxt_s != stable_r) &&
            (stable_nxt_s != last_r);
    if (evt_s) begin
      last_nxt_s = stable_nxt_s;
    end else if (sweep_end_s && !stable_nxt_s[4]) begin
      last_nxt_s = KEY_NONE;
    end else begin
      last_nxt_s = last_r;
    end

    valid_nxt_s = valid_r;
    code_nxt_s  = code_r;
    ovf_nxt_s   = 1'b0;
    if (evt_s) begin
      if (!valid_r || evt.key_ready) begin
        valid_nxt_s = 1'b1;
        code_nxt_s  = stable_nxt_s[3:0];
      end else begin
        ovf_nxt_s   = 1'b1;
      end
    end else if (valid_r && evt.key_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_DRIVE;
      cnt_r       <= {CW{1'b0}};
      col_idx_r   <= 2'd0;
      col_r       <= 4'b1110;
      cand_r      <= KEY_NONE;
      prev_cand_r <= KEY_NONE;
      run_r       <= {RW{1'b0}};
      stable_r    <= KEY_NONE;
      last_r      <= KEY_NONE;
      valid_r     <= 1'b0;
      code_r      <= 4'h0;
      held_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      col_idx_r <= col_idx_nxt_s;
      col_r     <= ~(4'b0001 << col_idx_nxt_s);
      if (sample_s) begin
        cand_r <= sweep_cand_s;
      end
      if (sweep_end_s) begin
        prev_cand_r <= sweep_cand_s;
        run_r       <= run_nxt_s;
      end
      stable_r <= stable_nxt_s;
      last_r   <= last_nxt_s;
      valid_r  <= valid_nxt_s;
      code_r   <= code_nxt_s;
      held_r   <= stable_nxt_s[4];
      ovf_r    <= ovf_nxt_s;
    end
  end

  assign col           = col_r;
  assign evt.key_valid = valid_r;
  assign evt.key_code  = code_r;
  assign evt.key_held  = held_r;
  assign evt.overflow  = ovf_r;

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Directed bench for kypd_scan_ctrl with a behavioural 4x4 keypad model
// (SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, 20-cycle sweeps).
module tb_kypd_scan_ctrl;
  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keys;   // bit c*4+r set = key at (col c,row r) down

  kypd_scan_ctrl_if ifc ();

  kypd_scan_ctrl #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row   (row),
    .col   (col),
    .evt   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a row reads low when any pressed key on it sits in a driven-low column
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] keys;
    int          sweeps;
    logic        ready;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic        exp_held;
    int          exp_acc;
    logic [3:0]  exp_acc_code;
    int          exp_ovf;
  } vec_t;

  int         n_vec;
  int         n_miss;
  int         acc;
  int         ovf;
  logic [3:0] acc_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepts counted before each edge, overflow pulses after it
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (ifc.key_valid && ifc.key_ready) begin
        acc++;
        acc_code = ifc.key_code;
      end
      @(posedge clk);
      @(negedge clk);
      if (ifc.overflow) ovf++;
    end
  endtask

  vec_t vt[15];

  initial begin
    logic [3:0] exp_col;
    n_vec = 0; n_miss = 0; acc = 0; ovf = 0; acc_code = 4'h0;
    keys = 16'h0000;
    ifc.key_ready = 1'b0;
    rst_n = 1'b0;

    //            keys      sw rdy  val code held acc acode ovf
    vt[0]  = '{16'h0020, 4, 1'b1, 1'b0, 4'h0, 1'b1, 1, 4'h5, 0};
    vt[1]  = '{16'h0000, 2, 1'b1, 1'b0, 4'h0, 1'b0, 0, 4'h0, 0};
    vt[2]  = '{16'h0100, 1, 1'b1, 1'b0, 4'h0, 1'b0, 0, 4'h0, 0};
    vt[3]  = '{16'h0000, 1, 1'b1, 1'b0, 4'h0, 1'b0, 0, 4'h0, 0};
    vt[4]  = '{16'h0100, 1, 1'b1, 1'b0, 4'h0, 1'b0, 0, 4'h0, 0};
    vt[5]  = '{16'h0000, 1, 1'b1, 1'b0, 4'h0, 1'b0, 0, 4'h0, 0};
    vt[6]  = '{16'h0100, 1, 1'b1, 1'b0, 4'h0, 1'b0, 0, 4'h0, 0};
    vt[7]  = '{16'h0000, 1, 1'b1, 1'b0, 4'h0, 1'b0, 0, 4'h0, 0};
    vt[8]  = '{16'h8001, 3, 1'b1, 1'b0, 4'h0, 1'b1, 1, 4'h1, 0};
    vt[9]  = '{16'h0000, 2, 1'b1, 1'b0, 4'h0, 1'b0, 0, 4'h0, 0};
    vt[10] = '{16'h0100, 2, 1'b0, 1'b1, 4'h3, 1'b1, 0, 4'h0, 0};
    vt[11] = '{16'h0000, 2, 1'b0, 1'b1, 4'h3, 1'b0, 0, 4'h0, 0};
    vt[12] = '{16'h0400, 2, 1'b0, 1'b1, 4'h3, 1'b1, 0, 4'h0, 1};
    vt[13] = '{16'h0400, 1, 1'b1, 1'b0, 4'h0, 1'b1, 1, 4'h3, 0};
    vt[14] = '{16'h0000, 2, 1'b1, 1'b0, 4'h0, 1'b0, 0, 4'h0, 0};

    repeat (5) @(negedge clk);
    check("rst_col",   32'(col), 32'h0000000E);
    check("rst_valid", 32'(ifc.key_valid), 32'h0);
    check("rst_code",  32'(ifc.key_code), 32'h0);
    check("rst_held",  32'(ifc.key_held), 32'h0);
    check("rst_ovf",   32'(ifc.overflow), 32'h0);
    rst_n = 1'b1;

    // Column walk over the first sweep, no keys down
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_col = ~(4'b0001 << (((k + 1) / 5) % 4));
      check($sformatf("col_step%0d", k), 32'(col), 32'(exp_col));
    end

    for (int v = 0; v < 15; v++) begin
      keys = vt[v].keys;
      ifc.key_ready = vt[v].ready;
      acc = 0; ovf = 0;
      run_cycles(20 * vt[v].sweeps);
      check($sformatf("v%0d_valid", v), 32'(ifc.key_valid), 32'(vt[v].exp_valid));
      check($sformatf("v%0d_held", v),  32'(ifc.key_held), 32'(vt[v].exp_held));
      check($sformatf("v%0d_events", v), 32'(acc), 32'(vt[v].exp_acc));
      check($sformatf("v%0d_ovf", v), 32'(ovf), 32'(vt[v].exp_ovf));
      if (vt[v].exp_valid) check($sformatf("v%0d_code", v), 32'(ifc.key_code), 32'(vt[v].exp_code));
      if (vt[v].exp_acc > 0) check($sformatf("v%0d_evcode", v), 32'(acc_code), 32'(vt[v].exp_acc_code));
    end

    // Reset while an event is pending and the scan is mid-DRIVE of column 1
    ifc.key_ready = 1'b0;
    keys = 16'h0008;
    run_cycles(40);
    check("r6_pend_valid", 32'(ifc.key_valid), 32'h1);
    check("r6_pend_code",  32'(ifc.key_code), 32'h0);
    run_cycles(7);
    check("r6_mid_col", 32'(col), 32'h0000000D);
    rst_n = 1'b0;
    #1;
    check("r6_rst_col",   32'(col), 32'h0000000E);
    check("r6_rst_valid", 32'(ifc.key_valid), 32'h0);
    check("r6_rst_held",  32'(ifc.key_held), 32'h0);
    check("r6_rst_ovf",   32'(ifc.overflow), 32'h0);
    check("r6_rst_code",  32'(ifc.key_code), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_cycles(20);
    check("r6_sweep1_valid", 32'(ifc.key_valid), 32'h0);
    run_cycles(20);
    check("r6_sweep2_valid", 32'(ifc.key_valid), 32'h1);
    check("r6_sweep2_code",  32'(ifc.key_code), 32'h0);
    check("r6_sweep2_held",  32'(ifc.key_held), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
